cpu_ctrl: RTL and testbench

CPU_CTRL -- requirements
Module: cpu_ctrl

---
 rtl/cpu_pkg.sv | 25 ++
 rtl/cpu_pc.sv | 28 ++
 rtl/cpu_ctrl.sv | 151 +++++++++++++++
 tb/tb_cpu_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - opcode constants, FSM state encoding and decode helper for cpu_ctrl
package cpu_pkg;

  // Sequencer states; the encoding is visible on the debug state port.
  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_WB     = 3'd3,
    ST_HALT   = 3'd4
  } state_t;

  localparam logic [3:0] OP_NOP    = 4'h0;
  localparam logic [3:0] OP_ALU_LO = 4'h1;
  localparam logic [3:0] OP_ALU_HI = 4'hC;
  localparam logic [3:0] OP_BZ     = 4'hD;
  localparam logic [3:0] OP_JMP    = 4'hE;
  localparam logic [3:0] OP_HALT   = 4'hF;

  // True for the opcodes the ALU executes and that write the register file.
  function automatic logic is_alu_op(input logic [3:0] op);
    return (op >= OP_ALU_LO) && (op <= OP_ALU_HI);
  endfunction

endpackage

// File: rtl/cpu_pc.sv
// rtl/cpu_pc.sv - program counter register with load and 8-bit wrapping increment
module cpu_pc #(
  parameter logic [7:0] PC_RESET = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_load,
  input  logic       i_inc,
  input  logic [7:0] i_target,
  output logic [7:0] o_pc
);

  logic [7:0] r_pc;

  // Load has priority over increment; the increment wraps modulo 256 with no side effect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= PC_RESET;
    end else if (i_load) begin
      r_pc <= i_target;
    end else if (i_inc) begin
      r_pc <= r_pc + 8'd1;
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/cpu_ctrl.sv
// rtl/cpu_ctrl.sv - fetch/decode/exec/writeback sequencer driving an external ALU and register file
module cpu_ctrl
  import cpu_pkg::*;
#(
  parameter logic [7:0] PC_RESET = 8'h00,
  parameter logic [3:0] HALT_OP  = 4'hF
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [7:0]  imem_addr,
  input  logic        imem_ready,
  input  logic [11:0] imem_instr,
  output logic [3:0]  opcode,
  output logic [2:0]  dest,
  output logic [2:0]  src,
  input  logic [7:0]  alu_result,
  input  logic        alu_carry,
  output logic        rf_wen,
  output logic        zf,
  output logic        cf,
  output logic        halted,
  output logic [2:0]  state
);

  state_t      r_state;
  state_t      w_next_state;
  logic [11:0] r_ir;
  logic        r_zf;
  logic        r_cf;

  logic        w_ir_load;
  logic        w_flag_upd;
  logic        w_pc_load;
  logic        w_pc_inc;
  logic        w_rf_wen;
  logic        w_req;
  logic [7:0]  w_pc;
  logic [3:0]  w_op;
  logic        w_is_halt;
  logic        w_is_alu;

  // The IR only changes in FETCH, so these fields hold steady from DECODE through WB.
  assign w_op      = r_ir[11:8];
  assign w_is_halt = (w_op == HALT_OP);
  assign w_is_alu  = is_alu_op(w_op) && !w_is_halt;

  cpu_pc #(
    .PC_RESET (PC_RESET)
  ) u_pc (
    .clk      (clk),
    .rst_n    (rst),
    .i_load   (w_pc_load),
    .i_inc    (w_pc_inc),
    .i_target (r_ir[7:0]),
    .o_pc     (w_pc)
  );

  // State register; an asynchronous reset drops back to FETCH, aborting the instruction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_FETCH;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Instruction register, captured on the completing fetch cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ir <= 12'h000;
    end else if (w_ir_load) begin
      r_ir <= imem_instr;
    end
  end

  // Flags are written only at the end of EXEC of an ALU op; BZ reads the older value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_zf <= 1'b0;
      r_cf <= 1'b0;
    end else if (w_flag_upd) begin
      r_zf <= (alu_result == 8'h00);
      r_cf <= alu_carry;
    end
  end

  // Next-state and per-state control strobes.
  always_comb begin
    w_next_state = r_state;
    w_ir_load    = 1'b0;
    w_flag_upd   = 1'b0;
    w_pc_load    = 1'b0;
    w_pc_inc     = 1'b0;
    w_rf_wen     = 1'b0;
    w_req        = 1'b0;
    case (r_state)
      ST_FETCH: begin
        w_req = 1'b1;
        if (imem_ready) begin
          w_ir_load    = 1'b1;
          w_next_state = ST_DECODE;
        end
      end
      ST_DECODE: begin
        w_next_state = ST_EXEC;
      end
      ST_EXEC: begin
        w_flag_upd   = w_is_alu;
        w_next_state = ST_WB;
      end
      ST_WB: begin
        if (w_is_halt) begin
          w_next_state = ST_HALT;
        end else begin
          w_next_state = ST_FETCH;
          if (w_is_alu) begin
            w_rf_wen = 1'b1;
            w_pc_inc = 1'b1;
          end else if (w_op == OP_JMP) begin
            w_pc_load = 1'b1;
          end else if (w_op == OP_BZ) begin
            w_pc_load = r_zf;
            w_pc_inc  = !r_zf;
          end else begin
            w_pc_inc = 1'b1;
          end
        end
      end
      ST_HALT: begin
        w_next_state = ST_HALT;
      end
      default: begin
        w_next_state = ST_FETCH;
      end
    endcase
  end

  // The fetch request is additionally gated by reset so nothing is requested while held.
  assign imem_req  = w_req & rst;
  assign imem_addr = w_pc;
  assign opcode    = w_op;
  assign dest      = r_ir[7:5];
  assign src       = r_ir[4:2];
  assign rf_wen    = w_rf_wen;
  assign zf        = r_zf;
  assign cf        = r_cf;
  assign halted    = (r_state == ST_HALT);
  assign state     = r_state;

endmodule

// File: tb/tb_cpu_ctrl.sv
// tb/tb_cpu_ctrl.sv - directed and randomized self-checking bench for cpu_ctrl
module tb_cpu_ctrl;
  import cpu_pkg::*;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ready;
  logic [11:0] imem_instr;
  logic [3:0]  opcode;
  logic [2:0]  dest;
  logic [2:0]  src;
  logic [7:0]  alu_result;
  logic        alu_carry;
  logic        rf_wen;
  logic        zf;
  logic        cf;
  logic        halted;
  logic [2:0]  state;

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model of the architectural state.
  logic [7:0] m_pc;
  logic       m_zf;
  logic       m_cf;

  cpu_ctrl #(
    .PC_RESET (8'h00),
    .HALT_OP  (4'hF)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_instr (imem_instr),
    .opcode     (opcode),
    .dest       (dest),
    .src        (src),
    .alu_result (alu_result),
    .alu_carry  (alu_carry),
    .rf_wen     (rf_wen),
    .zf         (zf),
    .cf         (cf),
    .halted     (halted),
    .state      (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one instruction from a negedge in FETCH through WB; ends at the negedge
  // after WB. With abort set, reset is asserted during WB instead.
  task automatic run_instr(input logic [11:0] instr, input int delay,
                           input logic [7:0] res, input logic car, input bit abort);
    logic [3:0] op;
    bit         alu;
    op  = instr[11:8];
    alu = (op >= 4'd1) && (op <= 4'd12);
    for (int w = 0; w <= delay; w++) begin
      chk("fetch_state", state, ST_FETCH);
      chk("fetch_req", imem_req, 1);
      chk("fetch_addr", imem_addr, m_pc);
      chk("fetch_wen", rf_wen, 0);
      imem_ready = (w == delay);
      imem_instr = (w == delay) ? instr : 12'($urandom);
      @(negedge clk);
    end
    chk("dec_state", state, ST_DECODE);
    chk("dec_op", opcode, instr[11:8]);
    chk("dec_dest", dest, instr[7:5]);
    chk("dec_src", src, instr[4:2]);
    chk("dec_req", imem_req, 0);
    chk("dec_wen", rf_wen, 0);
    imem_ready = 1'($urandom);
    imem_instr = 12'($urandom);
    alu_result = res;
    alu_carry  = car;
    @(negedge clk);
    chk("exec_state", state, ST_EXEC);
    chk("exec_op", opcode, instr[11:8]);
    chk("exec_wen", rf_wen, 0);
    imem_ready = 1'($urandom);
    @(negedge clk);
    if (alu) begin
      m_zf = (res == 8'h00);
      m_cf = car;
    end
    chk("wb_state", state, ST_WB);
    chk("wb_op", opcode, instr[11:8]);
    chk("wb_dest", dest, instr[7:5]);
    chk("wb_src", src, instr[4:2]);
    chk("wb_wen", rf_wen, alu);
    chk("wb_zf", zf, m_zf);
    chk("wb_cf", cf, m_cf);
    if (abort) begin
      rst = 1'b0;
      #1;
      m_pc = 8'h00;
      m_zf = 1'b0;
      m_cf = 1'b0;
      chk("abort_wen", rf_wen, 0);
      chk("abort_zf", zf, 0);
      chk("abort_cf", cf, 0);
      chk("abort_state", state, ST_FETCH);
      chk("abort_req", imem_req, 0);
      chk("abort_pc", imem_addr, m_pc);
      @(negedge clk);
      chk("abort_hold_wen", rf_wen, 0);
      rst = 1'b1;
      #1;
    end else begin
      case (op)
        4'hF:    m_pc = m_pc;
        4'hE:    m_pc = instr[7:0];
        4'hD:    m_pc = m_zf ? instr[7:0] : m_pc + 8'd1;
        default: m_pc = m_pc + 8'd1;
      endcase
      imem_ready = 1'($urandom);
      @(negedge clk);
    end
  endtask

  initial begin
    logic [3:0]  r_op;
    logic [7:0]  r_res;
    rst        = 1'b0;
    imem_ready = 1'b1;
    imem_instr = 12'hABC;
    alu_result = 8'h00;
    alu_carry  = 1'b0;
    m_pc = 8'h00;
    m_zf = 1'b0;
    m_cf = 1'b0;

    // Held in reset with a ready fetch port: nothing is requested or latched.
    repeat (3) @(negedge clk);
    chk("rst_state", state, ST_FETCH);
    chk("rst_req", imem_req, 0);
    chk("rst_pc", imem_addr, 8'h00);
    chk("rst_op", opcode, 4'h0);
    chk("rst_zf", zf, 0);
    chk("rst_cf", cf, 0);
    chk("rst_wen", rf_wen, 0);
    chk("rst_halted", halted, 0);
    rst = 1'b1;
    #1;

    // Basic ALU op, then fetch wait states, then BZ taken and not taken.
    run_instr(12'h124, 0, 8'h05, 1'b0, 0);
    chk("alu_pc", imem_addr, 8'h01);
    chk("alu_zf", zf, 0);
    run_instr(12'h2A8, 3, 8'h10, 1'b1, 0);
    run_instr(12'h314, 0, 8'h00, 1'b0, 0);
    chk("zf_set", zf, 1);
    run_instr(12'hD40, 1, 8'h77, 1'b1, 0);
    chk("bz_taken", imem_addr, 8'h40);
    run_instr(12'h5E0, 0, 8'h01, 1'b0, 0);
    run_instr(12'hD40, 0, 8'h00, 1'b0, 0);
    chk("bz_not_taken", imem_addr, 8'h42);

    // PC wrap via NOP at 8'hFF and an absolute jump.
    run_instr(12'hEFF, 0, 8'h00, 1'b0, 0);
    chk("jmp_ff", imem_addr, 8'hFF);
    run_instr(12'h000, 2, 8'h00, 1'b1, 0);
    chk("nop_wrap", imem_addr, 8'h00);
    run_instr(12'hE80, 0, 8'h00, 1'b0, 0);
    chk("jmp_80", imem_addr, 8'h80);

    // Random instruction mix, excluding HALT.
    for (int i = 0; i < 40; i++) begin
      r_op  = 4'($urandom_range(0, 14));
      r_res = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      run_instr({r_op, 8'($urandom)}, $urandom_range(0, 3), r_res, 1'($urandom), 0);
    end

    // HALT is terminal until reset.
    run_instr(12'hF12, 0, 8'h00, 1'b0, 0);
    for (int i = 0; i < 25; i++) begin
      chk("halt_state", state, ST_HALT);
      chk("halt_flag", halted, 1);
      chk("halt_req", imem_req, 0);
      chk("halt_pc", imem_addr, m_pc);
      chk("halt_wen", rf_wen, 0);
      imem_ready = 1'($urandom);
      @(negedge clk);
    end
    rst = 1'b0;
    #1;
    chk("halt_rst_state", state, ST_FETCH);
    chk("halt_rst_pc", imem_addr, 8'h00);
    chk("halt_rst_halted", halted, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    m_pc = 8'h00;
    m_zf = 1'b0;
    m_cf = 1'b0;

    // Reset during WB of an ALU op, then normal execution resumes from PC_RESET.
    run_instr(12'h000, 0, 8'h00, 1'b0, 0);
    run_instr(12'h7FC, 1, 8'h00, 1'b1, 1);
    run_instr(12'h9A4, 0, 8'h33, 1'b0, 0);
    chk("post_abort_pc", imem_addr, 8'h01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
